// File: rtl/tcb_cmn_gpio_irq_if.sv
// TCB common read/write channel used by tcb_cmn_gpio_irq.
// The manager drives vld/req; the subordinate drives rdy/rsp; trn marks a completed transfer.
interface tcb_if #(
   parameter int unsigned ABW = 32,
   parameter int unsigned DBW = 32,
   parameter int unsigned DLY = 0
) ();

   typedef struct packed {
      logic             wen;
      logic [ABW-1:0]   adr;
      logic [DBW/8-1:0] ben;
      logic [DBW-1:0]   wdt;
   } req_t;

   typedef struct packed {
      logic [DBW-1:0] rdt;
      logic           sts;
   } rsp_t;

   logic vld;
   logic rdy;
   logic trn;
   req_t req;
   rsp_t rsp;

   assign trn = vld & rdy;

   modport man (output vld, req, input rdy, rsp, trn);
   modport sub (input vld, req, trn, output rdy, rsp);

endinterface

// File: rtl/tcb_cmn_gpio_irq.sv
// GPIO peripheral on a zero-latency TCB channel with input synchronizer and
// optional edge-detect interrupt logic, enabled by defining TCB_CMN_GPIO_IRQ_EN.
module tcb_cmn_gpio_irq #(
   parameter int unsigned GW      = 32,
   parameter int unsigned CFG_CDC = 2
) (
   input  logic          clk,
   input  logic          rst,
   output logic [GW-1:0] gpio_o,
   output logic [GW-1:0] gpio_e,
   input  logic [GW-1:0] gpio_i,
   output logic          irq,
   tcb_if.sub            tcb
);

   localparam logic [3:0] A_OUT     = 4'd0;
   localparam logic [3:0] A_OE      = 4'd1;
   localparam logic [3:0] A_IN      = 4'd2;
   localparam logic [3:0] A_SET     = 4'd3;
   localparam logic [3:0] A_CLR     = 4'd4;
   localparam logic [3:0] A_TGL     = 4'd5;
   localparam logic [3:0] A_RISE_EN = 4'd6;
   localparam logic [3:0] A_FALL_EN = 4'd7;
   localparam logic [3:0] A_STATUS  = 4'd8;
   localparam logic [3:0] A_IRQ_EN  = 4'd9;

   if (tcb.DLY != 0) begin : g_bad_dly
      $error("tcb_cmn_gpio_irq: TCB DLY must be 0");
   end
   if (tcb.DBW != 32) begin : g_bad_dbw
      $error("tcb_cmn_gpio_irq: TCB DBW must be 32");
   end
   if (GW < 1 || GW > 32) begin : g_bad_gw
      $error("tcb_cmn_gpio_irq: GW must be in 1..32");
   end

   logic [3:0]    idx;
   logic          wr_en;
   logic [GW-1:0] wr_data;
   logic [GW-1:0] in_w;
   logic [31:0]   rd_data;
   logic          unused_w;

   logic [GW-1:0] out_q, out_d;
   logic [GW-1:0] oe_q, oe_d;

   assign idx     = tcb.req.adr[5:2];
   assign wr_en   = tcb.trn & tcb.req.wen;
   assign wr_data = tcb.req.wdt[GW-1:0];
   assign unused_w = ^{tcb.req.adr, tcb.req.ben, tcb.req.wdt};

   assign tcb.rdy     = 1'b1;
   assign tcb.rsp.sts = 1'b0;
   assign tcb.rsp.rdt = rd_data;

   assign gpio_o = out_q;
   assign gpio_e = oe_q;

   // Pin inputs pass through CFG_CDC flops; depth 0 exposes the raw pins.
   if (CFG_CDC == 0) begin : g_no_sync
      assign in_w = gpio_i;
   end else begin : g_sync
      logic [GW-1:0] sync_q [CFG_CDC];
      logic [GW-1:0] sync_d [CFG_CDC];

      always_comb begin
         sync_d[0] = gpio_i;
         for (int i = 1; i < int'(CFG_CDC); i++) begin
            sync_d[i] = sync_q[i-1];
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i < int'(CFG_CDC); i++) begin
               sync_q[i] <= '0;
            end
         end else begin
            for (int i = 0; i < int'(CFG_CDC); i++) begin
               sync_q[i] <= sync_d[i];
            end
         end
      end

      assign in_w = sync_q[CFG_CDC-1];
   end

   always_comb begin
      out_d = out_q;
      oe_d  = oe_q;
      if (wr_en) begin
         case (idx)
            A_OUT:   out_d = wr_data;
            A_OE:    oe_d  = wr_data;
            A_SET:   out_d = out_q | wr_data;
            A_CLR:   out_d = out_q & ~wr_data;
            A_TGL:   out_d = out_q ^ wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
         oe_q  <= '0;
      end else begin
         out_q <= out_d;
         oe_q  <= oe_d;
      end
   end

`ifdef TCB_CMN_GPIO_IRQ_EN
   logic [GW-1:0] rise_en_q, rise_en_d;
   logic [GW-1:0] fall_en_q, fall_en_d;
   logic [GW-1:0] irq_en_q, irq_en_d;
   logic [GW-1:0] status_q, status_d;
   logic [GW-1:0] p_q, p_d;
   logic          irq_q, irq_d;
   logic [GW-1:0] evt;

   // Events come only from IN/P transitions; a W1C and a new event on the same bit leave it set.
   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      irq_en_d  = irq_en_q;
      if (wr_en) begin
         case (idx)
            A_RISE_EN: rise_en_d = wr_data;
            A_FALL_EN: fall_en_d = wr_data;
            A_IRQ_EN:  irq_en_d  = wr_data;
            default:   ;
         endcase
      end
      evt      = (in_w & ~p_q & rise_en_q) | (~in_w & p_q & fall_en_q);
      status_d = status_q;
      if (wr_en && (idx == A_STATUS)) begin
         status_d = status_q & ~wr_data;
      end
      status_d = status_d | evt;
      p_d      = in_w;
      irq_d    = |(status_q & irq_en_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         irq_en_q  <= '0;
         status_q  <= '0;
         p_q       <= '0;
         irq_q     <= 1'b0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         irq_en_q  <= irq_en_d;
         status_q  <= status_d;
         p_q       <= p_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;

   always_comb begin
      rd_data = '0;
      case (idx)
         A_OUT:     rd_data[GW-1:0] = out_q;
         A_OE:      rd_data[GW-1:0] = oe_q;
         A_IN:      rd_data[GW-1:0] = in_w;
         A_RISE_EN: rd_data[GW-1:0] = rise_en_q;
         A_FALL_EN: rd_data[GW-1:0] = fall_en_q;
         A_STATUS:  rd_data[GW-1:0] = status_q;
         A_IRQ_EN:  rd_data[GW-1:0] = irq_en_q;
         default:   ;
      endcase
   end
`else
   assign irq = 1'b0;

   always_comb begin
      rd_data = '0;
      case (idx)
         A_OUT:   rd_data[GW-1:0] = out_q;
         A_OE:    rd_data[GW-1:0] = oe_q;
         A_IN:    rd_data[GW-1:0] = in_w;
         default: ;
      endcase
   end
`endif

endmodule

// File: tb/tb_tcb_cmn_gpio_irq.sv
// Self-checking bench for tcb_cmn_gpio_irq: bus register access, synchronizer
// latency, edge interrupts (when TCB_CMN_GPIO_IRQ_EN is defined) and async reset.
module tb_tcb_cmn_gpio_irq;

   logic        clk;
   logic        rst;
   logic [31:0] gpioO, gpioE, gpioI;
   logic        irq;
   logic [7:0]  gpioOB, gpioEB, gpioIB;
   logic        irqB;

   int total = 0;
   int bad   = 0;

   logic [31:0] expQ[$];
   string       tagQ[$];

   tcb_if #(.ABW(32), .DBW(32), .DLY(0)) tcbA ();
   tcb_if #(.ABW(32), .DBW(32), .DLY(0)) tcbB ();

   tcb_cmn_gpio_irq #(.GW(32), .CFG_CDC(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .gpio_o (gpioO),
      .gpio_e (gpioE),
      .gpio_i (gpioI),
      .irq    (irq),
      .tcb    (tcbA)
   );

   tcb_cmn_gpio_irq #(.GW(8), .CFG_CDC(0)) dutB (
      .clk    (clk),
      .rst    (rst),
      .gpio_o (gpioOB),
      .gpio_e (gpioEB),
      .gpio_i (gpioIB),
      .irq    (irqB),
      .tcb    (tcbB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input string tag, input logic [31:0] value);
      tagQ.push_back(tag);
      expQ.push_back(value);
   endtask

   task automatic popCheck(input logic [31:0] observed);
      string       t;
      logic [31:0] e;
      t = tagQ.pop_front();
      e = expQ.pop_front();
      checkOutput(t, observed, e);
   endtask

   task automatic expectNow(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      pushExp(tag, expected);
      popCheck(observed);
   endtask

   // Bus write: fields driven now, accepted on the next rising edge.
   task automatic applyStimulus(input logic [5:0] adr, input logic [31:0] data);
      tcbA.vld      = 1'b1;
      tcbA.req.wen  = 1'b1;
      tcbA.req.adr  = {26'h0, adr};
      tcbA.req.ben  = 4'($urandom);
      tcbA.req.wdt  = data;
      @(posedge clk);
      #1;
      tcbA.vld      = 1'b0;
      tcbA.req.wen  = 1'b0;
   endtask

   // Bus read: expectation queued at drive time, compared mid-cycle against rdt.
   task automatic busRead(input string tag, input logic [5:0] adr, input logic [31:0] expected);
      pushExp(tag, expected);
      tcbA.vld     = 1'b1;
      tcbA.req.wen = 1'b0;
      tcbA.req.adr = {26'h0, adr};
      @(negedge clk);
      popCheck(tcbA.rsp.rdt);
      @(posedge clk);
      #1;
      tcbA.vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b0;
      gpioI = '0;
      gpioIB = '0;
      tcbA.vld = 1'b0;
      tcbA.req = '0;
      tcbB.vld = 1'b0;
      tcbB.req = '0;

      #12;
      expectNow("rst_gpio_o", gpioO, 32'h0);
      expectNow("rst_gpio_e", gpioE, 32'h0);
      expectNow("rst_irq", {31'h0, irq}, 32'h0);

      // Release between edges; the very next edge must accept a transfer.
      #10;
      rst = 1'b1;
      applyStimulus(6'h00, 32'h0000_00F0);
      expectNow("out_wr", gpioO, 32'h0000_00F0);
      expectNow("rdy", {31'h0, tcbA.rdy}, 32'h1);
      expectNow("sts", {31'h0, tcbA.rsp.sts}, 32'h0);
      applyStimulus(6'h0C, 32'h0000_000F);
      expectNow("out_set", gpioO, 32'h0000_00FF);
      applyStimulus(6'h10, 32'h0000_0030);
      expectNow("out_clr", gpioO, 32'h0000_00CF);
      applyStimulus(6'h14, 32'h0000_0101);
      expectNow("out_tgl", gpioO, 32'h0000_01CE);
      busRead("rd_set", 6'h0C, 32'h0);
      busRead("rd_out", 6'h00, 32'h0000_01CE);
      applyStimulus(6'h04, 32'hA5A5_0F0F);
      expectNow("oe_wr", gpioE, 32'hA5A5_0F0F);
      busRead("rd_oe", 6'h04, 32'hA5A5_0F0F);
      busRead("rd_unmapped", 6'h28, 32'h0);
      applyStimulus(6'h08, 32'hFFFF_FFFF);
      applyStimulus(6'h3C, 32'hFFFF_FFFF);
      busRead("ro_ignored", 6'h08, 32'h0);
      busRead("unmapped_ignored", 6'h00, 32'h0000_01CE);

      // Narrow instance without synchronizer: masking and combinational IN.
      tcbB.vld     = 1'b1;
      tcbB.req.wen = 1'b1;
      tcbB.req.adr = 32'h0;
      tcbB.req.wdt = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      tcbB.req.wen = 1'b0;
      expectNow("b_gpio_o", {24'h0, gpioOB}, 32'h0000_00FF);
      #1;
      expectNow("b_out_mask", tcbB.rsp.rdt, 32'h0000_00FF);
      gpioIB       = 8'hA5;
      tcbB.req.adr = 32'h8;
      #1;
      expectNow("b_in_comb", tcbB.rsp.rdt, 32'h0000_00A5);
      tcbB.vld = 1'b0;
      idle(1);

      // Two-flop synchronizer: visible after two edges, not after one.
      gpioI = 32'h8;
      busRead("in_0edge", 6'h08, 32'h0);
      busRead("in_1edge", 6'h08, 32'h0);
      busRead("in_2edge", 6'h08, 32'h8);
      gpioI = 32'h0;
      idle(3);

`ifdef TCB_CMN_GPIO_IRQ_EN
      applyStimulus(6'h18, 32'h1);
      applyStimulus(6'h24, 32'h1);
      gpioI = 32'h1;
      idle(3);
      expectNow("irq_lag", {31'h0, irq}, 32'h0);
      busRead("st_rise", 6'h20, 32'h1);
      expectNow("irq_set", {31'h0, irq}, 32'h1);
      applyStimulus(6'h20, 32'h1);
      expectNow("irq_hold", {31'h0, irq}, 32'h1);
      busRead("st_w1c", 6'h20, 32'h0);
      expectNow("irq_clr", {31'h0, irq}, 32'h0);

      applyStimulus(6'h1C, 32'h1);
      applyStimulus(6'h18, 32'h0);
      applyStimulus(6'h18, 32'h1);
      idle(2);
      busRead("en_no_evt", 6'h20, 32'h0);

      applyStimulus(6'h1C, 32'h4);
      gpioI = 32'h5;
      idle(3);
      gpioI = 32'h1;
      idle(2);
      applyStimulus(6'h20, 32'h4);
      busRead("set_wins", 6'h20, 32'h4);
      expectNow("irq_masked", {31'h0, irq}, 32'h0);
      applyStimulus(6'h24, 32'h4);
      idle(1);
      expectNow("irq_en4", {31'h0, irq}, 32'h1);
      applyStimulus(6'h24, 32'h0);
      idle(1);
      expectNow("irq_dis", {31'h0, irq}, 32'h0);
      busRead("st_kept", 6'h20, 32'h4);
`endif

      // Asynchronous reset in the middle of a cycle.
      applyStimulus(6'h00, 32'hFFFF_FFFF);
      applyStimulus(6'h04, 32'h0000_FFFF);
`ifdef TCB_CMN_GPIO_IRQ_EN
      applyStimulus(6'h24, 32'h4);
      idle(1);
      expectNow("irq_pre_rst", {31'h0, irq}, 32'h1);
`endif
      gpioI = 32'h1;
      #2;
      rst = 1'b0;
      #1;
      expectNow("arst_gpio_o", gpioO, 32'h0);
      expectNow("arst_gpio_e", gpioE, 32'h0);
      expectNow("arst_irq", {31'h0, irq}, 32'h0);
      expectNow("arst_b_gpio_o", {24'h0, gpioOB}, 32'h0);
      tcbA.vld     = 1'b1;
      tcbA.req.wen = 1'b0;
      tcbA.req.adr = 32'h20;
      #1;
      expectNow("arst_status", tcbA.rsp.rdt, 32'h0);
      tcbA.vld = 1'b0;

      @(negedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(6'h00, 32'h0000_005A);
      expectNow("first_xfer", gpioO, 32'h0000_005A);
      idle(4);
      busRead("no_evt_release", 6'h20, 32'h0);

      // Interrupt registers: live only when the feature is built.
      applyStimulus(6'h18, 32'h0000_00FF);
      gpioI = 32'h0000_000F;
      idle(4);
      gpioI = 32'h0;
      idle(4);
      applyStimulus(6'h24, 32'h0000_00FF);
      idle(2);
`ifdef TCB_CMN_GPIO_IRQ_EN
      busRead("rise_en_rd", 6'h18, 32'h0000_00FF);
      busRead("status_toggle", 6'h20, 32'h0000_000E);
      expectNow("irq_final", {31'h0, irq}, 32'h1);
`else
      busRead("rise_en_rd", 6'h18, 32'h0);
      busRead("status_rd", 6'h20, 32'h0);
      busRead("irq_en_rd", 6'h24, 32'h0);
      expectNow("irq_final", {31'h0, irq}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tcb_cmn_gpio_irq.md
TCB_CMN_GPIO_IRQ -- requirements
Module: tcb_cmn_gpio_irq

Interface
REQ-001 Parameter GW, 32: GPIO pin count; legal range 1..32; bits above GW-1 read as 0 and ignore writes.
REQ-002 Parameter CFG_CDC, 2: input synchronizer depth in flops; 0 bypasses the synchronizer.
REQ-003 Port clk  input  1: single clock; the TCB interface is synchronous to it.
REQ-004 Port rst  input  1: reset, asynchronous assertion, active-low.
REQ-005 Port gpio_o  output  GW: pin output values.
REQ-006 Port gpio_e  output  GW: pin output enables, 1 = drive.
REQ-007 Port gpio_i  input  GW: asynchronous pin inputs.
REQ-008 Port irq  output  1: level interrupt request.
REQ-009 Port tcb  tcb_if.sub  -: common RW channel, DLY=0, DBW=32; instantiation SHALL error on any other DLY/DBW or on GW>32.

Function
REQ-010 tcb.rdy SHALL be constant 1 and tcb.rsp.sts constant 0; a transfer occurs on every cycle with tcb.trn=1.
REQ-011 Decode SHALL use adr[5:0], word aligned; writes are full-word, and byte enables are ignored.
REQ-012 Map: 0x00 OUT (RW), 0x04 OE (RW), 0x08 IN (RO, synchronized), 0x0C OUT_SET (WO), 0x10 OUT_CLR (WO), 0x14 OUT_TGL (WO), 0x18 RISE_EN (RW), 0x1C FALL_EN (RW), 0x20 STATUS (RW1C), 0x24 IRQ_EN (RW).
REQ-013 Read data SHALL be combinational from the current address in the same cycle; WO and unmapped addresses read 0.
REQ-014 Writes SHALL take effect on the clock edge ending the transfer; writes to RO or unmapped addresses SHALL be ignored.
REQ-015 OUT_SET SHALL compute OUT|wdt, OUT_CLR SHALL compute OUT&~wdt, and OUT_TGL SHALL compute OUT^wdt; gpio_o SHALL equal OUT.
REQ-016 With CFG_CDC=N>0, a gpio_i change SHALL appear in IN after exactly N clk edges; with CFG_CDC=0, IN SHALL equal gpio_i combinationally.
REQ-017 A previous-sample register P SHALL hold IN delayed by 1 cycle; rise=IN&~P&RISE_EN and fall=~IN&P&FALL_EN per bit.
REQ-018 STATUS bit SHALL set on the edge after rise|fall is detected and SHALL stay set until cleared by writing 1 to that bit.
REQ-019 A W1C write and a new detected event on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-020 irq SHALL be registered: irq = |(STATUS & IRQ_EN) evaluated one cycle earlier; disabling IRQ_EN SHALL not clear STATUS.
REQ-021 Changing RISE_EN or FALL_EN SHALL NOT itself generate an event; only IN/P transitions do.

Reset
REQ-022 On rst low, OUT, OE, RISE_EN, FALL_EN, STATUS, IRQ_EN, irq, P and all synchronizer flops SHALL clear to 0 asynchronously.
REQ-023 Reset SHALL release synchronously with clk; the first transfer SHALL be accepted on the first edge with rst high.
REQ-024 Because the edge enables reset to 0, a pin high at reset release SHALL NOT set STATUS.

Configuration
REQ-025 Macro TCB_CMN_GPIO_IRQ_EN: when defined, REQ-017..REQ-021 and REQ-024 SHALL be implemented.
REQ-026 Without TCB_CMN_GPIO_IRQ_EN, offsets 0x18..0x24 SHALL read 0 and ignore writes, irq SHALL be tied to 0, and no P/STATUS flops SHALL be built.

Verification
REQ-027 Write OUT=0x0000_00F0, then OUT_SET 0x0F, then OUT_CLR 0x30, then OUT_TGL 0x101 -> gpio_o values 0xF0, 0xFF, 0xCF, 0x1CE, each the cycle after its write; reading 0x0C returns 0.
REQ-028 CFG_CDC=2, gpio_i[3] 0->1 -> IN read at 0x08 shows 0x8 after exactly 2 edges, not after 1.
REQ-029 RISE_EN=0x1, IRQ_EN=0x1, gpio_i[0] 0->1 -> STATUS=0x1 and irq=1 on the following cycles; write STATUS=0x1 -> STATUS=0 and irq=0 one cycle later.
REQ-030 FALL_EN=0x4, W1C of bit 2 issued in the same cycle a falling edge is detected on pin 2 -> STATUS[2] remains 1.
REQ-031 Assert rst mid-operation with OUT=0xFFFF_FFFF and STATUS=0x3 -> gpio_o, gpio_e, STATUS and irq read 0 immediately, without a clock edge.
REQ-032 Build without TCB_CMN_GPIO_IRQ_EN, write 0xFF to 0x18 and toggle pins -> reading 0x18 returns 0 and irq stays 0.
